// File: rtl/ifid_buffer_pkg.sv
// Shared pipeline definitions for the IF/ID and ID/EX boundary registers:
// widths, the bubble encoding and the per-stage instruction record.
package ifid_buffer_pkg;

  localparam int INS_W = 32;
  localparam int PC_W  = 32;
  localparam logic [INS_W-1:0] NOP = 32'h0000_0000;  // sll $0,$0,0

  typedef struct packed {
    logic [INS_W-1:0] ins;
    logic [PC_W-1:0]  npc;
    logic             valid;
  } pipe_ins_t;

  function automatic pipe_ins_t mk_entry(input logic [INS_W-1:0] ins,
                                         input logic [PC_W-1:0]  npc,
                                         input logic             valid);
    pipe_ins_t e;
    e.ins   = ins;
    e.npc   = npc;
    e.valid = valid;
    return e;
  endfunction

endpackage

// File: rtl/ifid_buffer.sv
// IF/ID boundary register with a one-entry skid buffer. Parks the in-flight
// fetch while decode is held, back-pressures fetch, and flushes to a bubble.
module ifid_buffer #(
  parameter int                 INS_W = ifid_buffer_pkg::INS_W,
  parameter int                 PC_W  = ifid_buffer_pkg::PC_W,
  parameter logic [INS_W-1:0]   NOP   = ifid_buffer_pkg::NOP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INS_W-1:0] insIF,
  input  logic [PC_W-1:0]  nPCIF,
  input  logic             validIF,
  input  logic             hold,
  input  logic             flush,
  output logic [INS_W-1:0] insID,
  output logic [PC_W-1:0]  nPCID,
  output logic             validID,
  output logic             stallIF,
  output logic             overflow
);
  import ifid_buffer_pkg::*;

  pipe_ins_t r_id;
  pipe_ins_t r_skid;
  logic      r_overflow;

  pipe_ins_t w_id_nxt;
  pipe_ins_t w_skid_nxt;
  pipe_ins_t w_incoming;
  pipe_ins_t w_bubble;
  logic      w_overflow_nxt;

  assign w_incoming = mk_entry(insIF, nPCIF, 1'b1);
  assign w_bubble   = mk_entry(NOP, {PC_W{1'b0}}, 1'b0);

  // Next-state selection: flush beats hold beats advance.
  always_comb begin
    w_id_nxt       = r_id;
    w_skid_nxt     = r_skid;
    w_overflow_nxt = r_overflow;
    if (flush) begin
      w_id_nxt         = w_bubble;
      w_skid_nxt.valid = 1'b0;
    end else if (hold) begin
      if (!r_skid.valid) begin
        if (validIF) begin
          w_skid_nxt = w_incoming;
        end else begin
          w_skid_nxt = r_skid;
        end
      end else begin
        // Fetch ignored stallIF: the new instruction has nowhere to go.
        if (validIF) begin
          w_overflow_nxt = 1'b1;
        end else begin
          w_overflow_nxt = r_overflow;
        end
      end
    end else begin
      if (r_skid.valid) begin
        w_id_nxt = r_skid;
        if (validIF) begin
          w_skid_nxt = w_incoming;
        end else begin
          w_skid_nxt.valid = 1'b0;
        end
      end else begin
        if (validIF) begin
          w_id_nxt = w_incoming;
        end else begin
          w_id_nxt = w_bubble;
        end
      end
    end
  end

  // State registers; reset discards both entries and the error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_id       <= w_bubble;
      r_skid     <= mk_entry({INS_W{1'b0}}, {PC_W{1'b0}}, 1'b0);
      r_overflow <= 1'b0;
    end else begin
      r_id       <= w_id_nxt;
      r_skid     <= w_skid_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  assign insID    = r_id.ins;
  assign nPCID    = r_id.npc;
  assign validID  = r_id.valid;
  assign stallIF  = r_skid.valid;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_ifid_buffer.sv
// Directed bench for ifid_buffer: a slot-plus-parked-queue model checked on
// every falling edge, plus hand-computed expectations along the test plan.
module tb_ifid_buffer;

  logic        clk;
  logic        reset;
  logic [31:0] insIF;
  logic [31:0] nPCIF;
  logic        validIF;
  logic        hold;
  logic        flush;
  logic [31:0] insID;
  logic [31:0] nPCID;
  logic        validID;
  logic        stallIF;
  logic        overflow;

  int n_total;
  int n_pass;

  // model: what decode sees now, plus instructions parked behind it
  logic [31:0] m_ins;
  logic [31:0] m_npc;
  logic        m_valid;
  logic [63:0] m_parked[$];
  logic        m_ovf;

  ifid_buffer dut (
    .clk(clk), .reset(reset), .insIF(insIF), .nPCIF(nPCIF),
    .validIF(validIF), .hold(hold), .flush(flush),
    .insID(insID), .nPCID(nPCID), .validID(validID),
    .stallIF(stallIF), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_ins   = 32'h0000_0000;
    m_npc   = 32'h0000_0000;
    m_valid = 1'b0;
    m_parked.delete();
    m_ovf   = 1'b0;
  endtask

  task automatic model_edge();
    logic [63:0] head;
    if (flush) begin
      m_ins = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
      m_parked.delete();
    end else if (hold) begin
      if (validIF) begin
        if (m_parked.size() == 0) m_parked.push_back({insIF, nPCIF});
        else m_ovf = 1'b1;
      end
    end else if (m_parked.size() != 0) begin
      head = m_parked.pop_front();
      m_ins = head[63:32]; m_npc = head[31:0]; m_valid = 1'b1;
      if (validIF) m_parked.push_back({insIF, nPCIF});
    end else if (validIF) begin
      m_ins = insIF; m_npc = nPCIF; m_valid = 1'b1;
    end else begin
      m_ins = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // continuous comparison against the model
  always @(negedge clk) begin
    logic [31:0] exp_stall;
    exp_stall = (m_parked.size() != 0) ? 32'd1 : 32'd0;
    n_total++;
    if (insID === m_ins && nPCID === m_npc && validID === m_valid &&
        stallIF === exp_stall[0] && overflow === m_ovf)
      n_pass++;
    else
      $display("FAIL model t=%0t: got ins=%h npc=%h v=%b st=%b ov=%b expected ins=%h npc=%h v=%b st=%b ov=%b",
               $time, insID, nPCID, validID, stallIF, overflow,
               m_ins, m_npc, m_valid, exp_stall[0], m_ovf);
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] npc,
                      input logic h, input logic f);
    validIF = v; insIF = ins; nPCIF = npc; hold = h; flush = f;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_out(input string name, input logic [31:0] ins, input logic [31:0] npc,
                           input logic v, input logic st, input logic ov);
    check({name, ".ins"}, insID, ins);
    check({name, ".npc"}, nPCID, npc);
    check({name, ".valid"}, {31'd0, validID}, {31'd0, v});
    check({name, ".stall"}, {31'd0, stallIF}, {31'd0, st});
    check({name, ".ovf"}, {31'd0, overflow}, {31'd0, ov});
  endtask

  initial begin
    n_total = 0; n_pass = 0;
    reset = 1'b0; validIF = 1'b0; insIF = 32'h0; nPCIF = 32'h0;
    hold = 1'b0; flush = 1'b0;
    model_reset();
    #1;
    check_out("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); model_edge(); #1;

    // stream
    step(1'b1, 32'h2008_0005, 32'h4, 1'b0, 1'b0);
    check_out("stream0", 32'h2008_0005, 32'h4, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h2009_0007, 32'h8, 1'b0, 1'b0);
    check_out("stream1", 32'h2009_0007, 32'h8, 1'b1, 1'b0, 1'b0);

    // single-cycle hold: A, B parked, then B, then C
    step(1'b1, 32'hA000_0001, 32'h10, 1'b0, 1'b0);
    step(1'b1, 32'hB000_0002, 32'h14, 1'b1, 1'b0);
    check_out("hold1.a", 32'hA000_0001, 32'h10, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_out("hold1.b", 32'hB000_0002, 32'h14, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hC000_0003, 32'h18, 1'b0, 1'b0);
    check_out("hold1.c", 32'hC000_0003, 32'h18, 1'b1, 1'b0, 1'b0);

    // three-cycle hold with fetch obeying stallIF
    step(1'b1, 32'hA100_0011, 32'h20, 1'b0, 1'b0);
    step(1'b1, 32'hB100_0012, 32'h24, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check_out("hold3.a", 32'hA100_0011, 32'h20, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_out("hold3.b", 32'hB100_0012, 32'h24, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hC100_0013, 32'h28, 1'b0, 1'b0);
    check_out("hold3.c", 32'hC100_0013, 32'h28, 1'b1, 1'b0, 1'b0);

    // advance with skid full and a new fetch arriving: no loss
    step(1'b1, 32'hD200_0021, 32'h30, 1'b1, 1'b0);
    step(1'b1, 32'hE200_0022, 32'h34, 1'b0, 1'b0);
    check_out("skidref", 32'hD200_0021, 32'h30, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_out("skiddrain", 32'hE200_0022, 32'h34, 1'b1, 1'b0, 1'b0);

    // flush during hold with skid full
    step(1'b1, 32'hD000_0004, 32'h40, 1'b0, 1'b0);
    step(1'b1, 32'hE000_0005, 32'h44, 1'b1, 1'b0);
    step(1'b1, 32'hF000_0006, 32'h48, 1'b1, 1'b1);
    check_out("flush", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // protocol violation: third instruction dropped, overflow sticks
    step(1'b1, 32'h1100_0007, 32'h50, 1'b0, 1'b0);
    step(1'b1, 32'h2200_0008, 32'h54, 1'b1, 1'b0);
    step(1'b1, 32'h3300_0009, 32'h58, 1'b1, 1'b0);
    check_out("ovf.hold", 32'h1100_0007, 32'h50, 1'b1, 1'b1, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_out("ovf.drain", 32'h2200_0008, 32'h54, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_out("ovf.sticky", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    // asynchronous reset while stalled
    step(1'b1, 32'h4400_000A, 32'h60, 1'b0, 1'b0);
    step(1'b1, 32'h5500_000B, 32'h64, 1'b1, 1'b0);
    check_out("prereset", 32'h4400_000A, 32'h60, 1'b1, 1'b1, 1'b1);
    validIF = 1'b0; hold = 1'b0;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_out("asyncrst", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 32'h6600_000C, 32'h70, 1'b0, 1'b0);
    check_out("postrst", 32'h6600_000C, 32'h70, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
